// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage:
//   RESET_PC / EXC_VECTOR  default fetch and exception entry addresses
//   ST_*                   fetch FSM state encodings
//   redir_sel_e            redirect source, ordered by priority
//   pc_add4()              modulo-2^32 sequential address step
// Optional feature macro used by the stage: IF_ADDR_ALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

   localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   // Fetch FSM state encodings.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   // Redirect source; larger value means higher priority.
   typedef enum logic [2:0] {
      RD_NONE   = 3'd0,
      RD_BRANCH = 3'd1,
      RD_JUMP   = 3'd2,
      RD_JR     = 3'd3,
      RD_ERET   = 3'd4,
      RD_EXC    = 3'd5
   } redir_sel_e;

   // Sequential next address; wraps naturally at 2^32.
   function automatic logic [31:0] pc_add4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_if
// SRAM-like instruction bus, single outstanding access.
//   inst_req      fetch -> mem  request
//   inst_addr     fetch -> mem  request address
//   inst_addr_ok  mem -> fetch  address accepted this cycle
//   inst_data_ok  mem -> fetch  read data valid this cycle
//   inst_rdata    mem -> fetch  read data
// master: fetch stage side, slave: memory side.
// -----------------------------------------------------------------------------
interface if_fetch_stage_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok,
      input  inst_data_ok,
      input  inst_rdata
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok,
      output inst_data_ok,
      output inst_rdata
   );
endinterface

// File: rtl/if_fetch_stage_next_pc_sel.sv
// -----------------------------------------------------------------------------
// if_next_pc_sel
// Combinational next-PC selection.
//   exception_i / eret_i+epc_i / jump_reg_i+jr_addr_i / jump_i+jump_addr_i /
//   branch_taken_i+branch_addr_i   redirect requests, highest priority first
//   pc_plus4_i                     sequential address
//   redirect_o                     any redirect requested this cycle
//   target_o                       chosen next address (pc_plus4_i if none)
// -----------------------------------------------------------------------------
module if_next_pc_sel #(
   parameter logic [31:0] EXC_VECTOR = if_fetch_stage_pkg::EXC_VECTOR
) (
   input  logic        exception_i,
   input  logic        eret_i,
   input  logic [31:0] epc_i,
   input  logic        jump_reg_i,
   input  logic [31:0] jr_addr_i,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_addr_i,
   input  logic [31:0] pc_plus4_i,
   output logic        redirect_o,
   output logic [31:0] target_o
);
   import if_fetch_stage_pkg::*;

   redir_sel_e sel_s;

   // Priority encode the redirect sources.
   always_comb begin
      sel_s = RD_NONE;
      if (exception_i) begin
         sel_s = RD_EXC;
      end else if (eret_i) begin
         sel_s = RD_ERET;
      end else if (jump_reg_i) begin
         sel_s = RD_JR;
      end else if (jump_i) begin
         sel_s = RD_JUMP;
      end else if (branch_taken_i) begin
         sel_s = RD_BRANCH;
      end else begin
         sel_s = RD_NONE;
      end
   end

   // Map the selected source to its target address.
   always_comb begin
      target_o   = pc_plus4_i;
      redirect_o = 1'b1;
      case (sel_s)
         RD_EXC:    target_o = EXC_VECTOR;
         RD_ERET:   target_o = epc_i;
         RD_JR:     target_o = jr_addr_i;
         RD_JUMP:   target_o = jump_addr_i;
         RD_BRANCH: target_o = branch_addr_i;
         default: begin
            target_o   = pc_plus4_i;
            redirect_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// MIPS instruction-fetch stage: owns the fetch PC, issues one outstanding
// access on the instruction bus and registers results into the IF/ID boundary.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall, flush             hazard control of the IF/ID register
//   exception, eret+epc, jump_reg+jr_addr, jump+jump_addr,
//   branch_taken+branch_addr redirect pulses (priority in that order)
//   inst_bus                 instruction bus (master modport)
//   instr_o, pc_o, pc_plus_4_o, valid_o, adel_o   IF/ID outputs
// Macro IF_ADDR_ALIGN_CHECK_EN: when defined, a misaligned fetch address is not
// requested; an address-error bubble (adel_o=1) is presented instead.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = if_fetch_stage_pkg::RESET_PC,
   parameter logic [31:0] EXC_VECTOR = if_fetch_stage_pkg::EXC_VECTOR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              exception,
   input  logic              eret,
   input  logic [31:0]       epc,
   input  logic              jump_reg,
   input  logic [31:0]       jr_addr,
   input  logic              jump,
   input  logic [31:0]       jump_addr,
   input  logic              branch_taken,
   input  logic [31:0]       branch_addr,
   if_fetch_stage_if.master  inst_bus,
   output logic [31:0]       instr_o,
   output logic [31:0]       pc_o,
   output logic [31:0]       pc_plus_4_o,
   output logic              valid_o,
   output logic              adel_o
);
   import if_fetch_stage_pkg::*;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inflight_q, inflight_d;
   logic        cancel_q, cancel_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic        adel_sent_q, adel_sent_d;

   logic [31:0] instr_q, pc_out_q, pc4_q;
   logic        valid_q, adel_q;

   logic        redirect_s;
   logic [31:0] target_s;
   logic        misalign_s;
   logic        deliver_s;
   logic [31:0] del_instr_s;
   logic [31:0] del_pc_s;
   logic        del_adel_s;

   if_next_pc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_next_pc_sel (
      .exception_i    (exception),
      .eret_i         (eret),
      .epc_i          (epc),
      .jump_reg_i     (jump_reg),
      .jr_addr_i      (jr_addr),
      .jump_i         (jump),
      .jump_addr_i    (jump_addr),
      .branch_taken_i (branch_taken),
      .branch_addr_i  (branch_addr),
      .pc_plus4_i     (pc_add4(pc_q)),
      .redirect_o     (redirect_s),
      .target_o       (target_s)
   );

`ifdef IF_ADDR_ALIGN_CHECK_EN
   assign misalign_s = (state_q == ST_REQ) && (pc_q[1:0] != 2'b00);
`else
   assign misalign_s = 1'b0;
`endif

   assign inst_bus.inst_req  = (state_q == ST_REQ) && !misalign_s;
   assign inst_bus.inst_addr = pc_q;

   // Fetch FSM next-state, PC selection and delivery decision.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inflight_d  = inflight_q;
      cancel_d    = cancel_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      adel_sent_d = adel_sent_q;
      deliver_s   = 1'b0;
      del_instr_s = 32'h0;
      del_pc_s    = pc_q;
      del_adel_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_s) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_REQ: begin
            if (misalign_s) begin
               // Parked on a bad address: report it once, then wait for a redirect.
               if (redirect_s) begin
                  pc_d        = target_s;
                  adel_sent_d = 1'b0;
               end else if (!stall && !adel_sent_q) begin
                  deliver_s   = 1'b1;
                  del_pc_s    = pc_q;
                  del_adel_s  = 1'b1;
                  adel_sent_d = 1'b1;
               end else begin
                  adel_sent_d = adel_sent_q;
               end
            end else if (inst_bus.inst_addr_ok) begin
               // target_s is pc+4 when no redirect is pending.
               inflight_d = pc_q;
               pc_d       = target_s;
               cancel_d   = redirect_s;
               state_d    = ST_WAIT;
            end else if (redirect_s) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_WAIT: begin
            if (inst_bus.inst_data_ok) begin
               if (cancel_q || redirect_s) begin
                  cancel_d = 1'b0;
                  state_d  = ST_REQ;
                  if (redirect_s) begin
                     pc_d = target_s;
                  end else begin
                     pc_d = pc_q;
                  end
               end else if (stall) begin
                  buf_instr_d = inst_bus.inst_rdata;
                  buf_pc_d    = inflight_q;
                  state_d     = ST_HOLD;
               end else begin
                  deliver_s   = 1'b1;
                  del_instr_s = inst_bus.inst_rdata;
                  del_pc_s    = inflight_q;
                  state_d     = ST_REQ;
               end
            end else if (redirect_s) begin
               pc_d     = target_s;
               cancel_d = 1'b1;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_HOLD: begin
            if (redirect_s) begin
               pc_d    = target_s;
               state_d = ST_REQ;
            end else if (!stall) begin
               deliver_s   = 1'b1;
               del_instr_s = buf_instr_q;
               del_pc_s    = buf_pc_q;
               state_d     = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Fetch FSM and PC-side registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         inflight_q  <= 32'h0;
         cancel_q    <= 1'b0;
         buf_instr_q <= 32'h0;
         buf_pc_q    <= 32'h0;
         adel_sent_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         cancel_q    <= cancel_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         adel_sent_q <= adel_sent_d;
      end
   end

   // IF/ID boundary register: stall holds, flush bubbles, else load delivery.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q  <= 32'h0;
         pc_out_q <= 32'h0;
         pc4_q    <= 32'h0;
         valid_q  <= 1'b0;
         adel_q   <= 1'b0;
      end else if (stall) begin
         instr_q  <= instr_q;
         pc_out_q <= pc_out_q;
         pc4_q    <= pc4_q;
         valid_q  <= valid_q;
         adel_q   <= adel_q;
      end else if (flush) begin
         valid_q  <= 1'b0;
         adel_q   <= 1'b0;
      end else if (deliver_s) begin
         instr_q  <= del_instr_s;
         pc_out_q <= del_pc_s;
         pc4_q    <= pc_add4(del_pc_s);
         valid_q  <= 1'b1;
         adel_q   <= del_adel_s;
      end else begin
         valid_q  <= 1'b0;
         adel_q   <= 1'b0;
      end
   end

   assign instr_o     = instr_q;
   assign pc_o        = pc_out_q;
   assign pc_plus_4_o = pc4_q;
   assign valid_o     = valid_q;
   assign adel_o      = adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed stimulus for if_fetch_stage. The stimulus process plays the
// instruction memory and pushes each instruction it expects decode to see into
// a scoreboard queue; a monitor pops and compares on every new valid_o.
// Define IF_ADDR_ALIGN_CHECK_EN to exercise the address-error path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, exception, eret, jump_reg, jump, branch_taken;
   logic [31:0] epc, jr_addr, jump_addr, branch_addr;
   logic [31:0] instr_o, pc_o, pc_plus_4_o;
   logic        valid_o, adel_o;

   if_fetch_stage_if bus();

   if_fetch_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .exception    (exception),
      .eret         (eret),
      .epc          (epc),
      .jump_reg     (jump_reg),
      .jr_addr      (jr_addr),
      .jump         (jump),
      .jump_addr    (jump_addr),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .inst_bus     (bus),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .pc_plus_4_o  (pc_plus_4_o),
      .valid_o      (valid_o),
      .adel_o       (adel_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        adel;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   logic edge_stall = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a request, check its address, accept it.
   task automatic accept(input logic [31:0] addr, input string nm);
      int n = 0;
      while (!bus.inst_req && n < 20) begin
         cyc();
         n++;
      end
      chk1({nm, "_req"}, bus.inst_req, 1'b1);
      chk({nm, "_addr"}, bus.inst_addr, addr);
      bus.inst_addr_ok = 1'b1;
      cyc();
      bus.inst_addr_ok = 1'b0;
   endtask

   task automatic give(input logic [31:0] d);
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = d;
      cyc();
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
   endtask

   task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc, input logic adel);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.adel  = adel;
      sb_q.push_back(e);
   endtask

   // Remember whether the edge that produced the current outputs was stalled.
   always @(posedge clk) edge_stall <= stall;

   // Scoreboard monitor: every freshly loaded valid_o must match the queue head.
   always @(negedge clk) begin
      if (!rst && valid_o && !edge_stall) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %h instr %h expected no output", pc_o, instr_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_instr", instr_o, e.instr);
            chk("sb_pc", pc_o, e.pc);
            chk("sb_pc4", pc_plus_4_o, e.pc + 32'd4);
            chk1("sb_adel", adel_o, e.adel);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; exception = 1'b0; eret = 1'b0;
      epc = 32'h0; jump_reg = 1'b0; jr_addr = 32'h0; jump = 1'b0; jump_addr = 32'h0;
      branch_taken = 1'b0; branch_addr = 32'h0;
      bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
      cyc();
      cyc();
      chk1("rst_req", bus.inst_req, 1'b0);
      chk("rst_addr", bus.inst_addr, 32'hBFC0_0000);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_pc4", pc_plus_4_o, 32'h0);
      chk1("rst_valid", valid_o, 1'b0);
      chk1("rst_adel", adel_o, 1'b0);
      rst = 1'b0;
      cyc();

      // Best-case fetch.
      chk1("t1_req", bus.inst_req, 1'b1);
      chk("t1_addr", bus.inst_addr, 32'hBFC0_0000);
      bus.inst_addr_ok = 1'b1;
      cyc();
      bus.inst_addr_ok = 1'b0;
      chk1("t1_wait_noreq", bus.inst_req, 1'b0);
      expect_out(32'h2408_0001, 32'hBFC0_0000, 1'b0);
      give(32'h2408_0001);
      chk1("t1_valid", valid_o, 1'b1);
      chk("t1_instr", instr_o, 32'h2408_0001);
      chk("t1_pc4", pc_plus_4_o, 32'hBFC0_0004);

      // Stall across data_ok: buffer, hold, release.
      accept(32'hBFC0_0004, "t2");
      stall = 1'b1;
      expect_out(32'h8C09_0004, 32'hBFC0_0004, 1'b0);
      give(32'h8C09_0004);
      for (int i = 0; i < 2; i++) begin
         chk1("t2_hold_noreq", bus.inst_req, 1'b0);
         chk1("t2_hold_valid", valid_o, 1'b0);
         chk("t2_hold_instr", instr_o, 32'h2408_0001);
         cyc();
      end
      chk1("t2_hold_noreq_last", bus.inst_req, 1'b0);
      stall = 1'b0;
      cyc();
      chk1("t2_rel_valid", valid_o, 1'b1);
      chk("t2_rel_instr", instr_o, 32'h8C09_0004);
      chk("t2_rel_pc", pc_o, 32'hBFC0_0004);

      // Branch while waiting: returned data is discarded.
      accept(32'hBFC0_0008, "t3");
      branch_taken = 1'b1;
      branch_addr  = 32'hBFC0_0100;
      cyc();
      branch_taken = 1'b0;
      chk1("t3_wait_noreq", bus.inst_req, 1'b0);
      give(32'hDEAD_BEEF);
      chk1("t3_valid", valid_o, 1'b0);
      chk("t3_addr", bus.inst_addr, 32'hBFC0_0100);
      expect_out(32'h3C1D_BFC0, 32'hBFC0_0100, 1'b0);
      accept(32'hBFC0_0100, "t3b");
      give(32'h3C1D_BFC0);
      chk("t3b_pc4", pc_plus_4_o, 32'hBFC0_0104);

      // Simultaneous exception, eret, jump: exception wins.
      exception = 1'b1; eret = 1'b1; epc = 32'h8000_0010;
      jump = 1'b1; jump_addr = 32'h8000_1000;
      cyc();
      exception = 1'b0; eret = 1'b0; jump = 1'b0;
      chk("t4_addr", bus.inst_addr, 32'hBFC0_0380);
      expect_out(32'h4200_0018, 32'hBFC0_0380, 1'b0);
      accept(32'hBFC0_0380, "t4");
      give(32'h4200_0018);

      // Redirect together with data_ok: data discarded.
      accept(32'hBFC0_0384, "t5");
      jump = 1'b1;
      jump_addr = 32'h8000_0000;
      give(32'h1111_1111);
      jump = 1'b0;
      chk1("t5_valid", valid_o, 1'b0);
      chk("t5_addr", bus.inst_addr, 32'h8000_0000);

      // Stall+flush: stall wins; flush alone bubbles.
      expect_out(32'hAAAA_0001, 32'h8000_0000, 1'b0);
      accept(32'h8000_0000, "t6");
      give(32'hAAAA_0001);
      chk1("t6_valid", valid_o, 1'b1);
      stall = 1'b1;
      flush = 1'b1;
      cyc();
      chk1("t6_sf_valid", valid_o, 1'b1);
      chk("t6_sf_instr", instr_o, 32'hAAAA_0001);
      stall = 1'b0;
      cyc();
      flush = 1'b0;
      chk1("t6_flush_valid", valid_o, 1'b0);

      // Address wrap.
      jump = 1'b1;
      jump_addr = 32'hFFFF_FFFC;
      cyc();
      jump = 1'b0;
      expect_out(32'hBBBB_0002, 32'hFFFF_FFFC, 1'b0);
      accept(32'hFFFF_FFFC, "t7");
      give(32'hBBBB_0002);
      chk("t7_pc4", pc_plus_4_o, 32'h0);
      chk("t7_addr", bus.inst_addr, 32'h0);

      // Misaligned register jump.
      jump_reg = 1'b1;
      jr_addr  = 32'h8000_0002;
      cyc();
      jump_reg = 1'b0;
`ifdef IF_ADDR_ALIGN_CHECK_EN
      chk1("t8_noreq", bus.inst_req, 1'b0);
      expect_out(32'h0, 32'h8000_0002, 1'b1);
      cyc();
      chk1("t8_valid", valid_o, 1'b1);
      chk1("t8_adel", adel_o, 1'b1);
      chk("t8_pc", pc_o, 32'h8000_0002);
      chk("t8_instr", instr_o, 32'h0);
      cyc();
      chk1("t8_park_noreq", bus.inst_req, 1'b0);
      chk1("t8_park_valid", valid_o, 1'b0);
      exception = 1'b1;
      cyc();
      exception = 1'b0;
      expect_out(32'h0000_000C, 32'hBFC0_0380, 1'b0);
      accept(32'hBFC0_0380, "t8r");
      give(32'h0000_000C);
`else
      chk1("t8_req", bus.inst_req, 1'b1);
      chk("t8_addr", bus.inst_addr, 32'h8000_0002);
      expect_out(32'hC0DE_0001, 32'h8000_0002, 1'b0);
      accept(32'h8000_0002, "t8");
      give(32'hC0DE_0001);
      chk1("t8_adel", adel_o, 1'b0);
`endif

      // Reset in the middle of an access; late data_ok ignored.
      accept(bus.inst_addr, "t9");
      rst = 1'b1;
      #1;
      chk1("t9_rst_req", bus.inst_req, 1'b0);
      chk("t9_rst_addr", bus.inst_addr, 32'hBFC0_0000);
      chk1("t9_rst_valid", valid_o, 1'b0);
      cyc();
      rst = 1'b0;
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = 32'hFFFF_FFFF;
      cyc();
      bus.inst_data_ok = 1'b0;
      chk1("t9_req", bus.inst_req, 1'b1);
      chk("t9_addr", bus.inst_addr, 32'hBFC0_0000);
      chk1("t9_valid", valid_o, 1'b0);
      expect_out(32'h2409_0002, 32'hBFC0_0000, 1'b0);
      accept(32'hBFC0_0000, "t9b");
      give(32'h2409_0002);

      cyc();
      cyc();
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
